// File: rtl/hazard_control_unit.sv
// Load-use and control hazard controller between the ID and EX stages of the MIPS pipeline.
// Produces PC/IF-ID enables, flushes and the ID/EX bubble select, plus a stall-cycle counter.
module hazard_control_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LOAD_LATENCY   = 1,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      id_uses_rt,
  input  logic                      idex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] idex_rt,
  input  logic                      ex_branch_taken,
  input  logic                      ext_stall,
  output logic                      pc_write,
  output logic                      ifid_write,
  output logic                      ifid_flush,
  output logic                      idex_bubble,
  output logic                      idex_flush,
  output logic                      stall_active,
  output logic [COUNT_WIDTH-1:0]    stall_cycles
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [3:0] CNT_RELOAD = 4'(LOAD_LATENCY - 1);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic                   detect_s;
  logic                   count_s;

  // Rs is always treated as a source; Rt only when the decoder says so. $zero never hazards.
  always_comb begin
    detect_s = idex_mem_read
               && (idex_rt != {REG_ADDR_WIDTH{1'b0}})
               && ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
  end

  // Next-state and output decode, priority reset > freeze > branch > STALL > detect.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    count_s      = 1'b0;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    idex_flush   = 1'b0;
    stall_active = 1'b0;

    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      state_d    = IDLE;
      cnt_d      = 4'd0;
    end else if (ext_stall) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      stall_active = (state_q == STALL);
    end else if (ex_branch_taken) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      stall_active = (state_q == STALL);
      state_d      = IDLE;
      cnt_d        = 4'd0;
    end else begin
      case (state_q)
        STALL: begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_bubble  = 1'b1;
          stall_active = 1'b1;
          count_s      = 1'b1;
          cnt_d        = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = IDLE;
          end else begin
            state_d = STALL;
          end
        end
        IDLE: begin
          if (detect_s) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
            stall_active = 1'b1;
            count_s      = 1'b1;
            // A single-cycle stall is fully served by this combinational response.
            if (LOAD_LATENCY > 1) begin
              state_d = STALL;
              cnt_d   = CNT_RELOAD;
            end else begin
              state_d = IDLE;
              cnt_d   = 4'd0;
            end
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // Saturating performance counter of load-use stall cycles.
  always_comb begin
    if (count_s && (stall_cycles_q != {COUNT_WIDTH{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // State, countdown and performance counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      stall_cycles_q <= {COUNT_WIDTH{1'b0}};
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench: four hazard_control_unit configurations share stimulus; each phase checks one.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs = 5'd0, id_rt = 5'd0, idex_rt = 5'd0;
  logic       id_uses_rt = 1'b0, idex_mem_read = 1'b0, ex_branch_taken = 1'b0, ext_stall = 1'b0;

  logic [5:0]  o0, o1, o2, o3;
  logic [15:0] sc0, sc1, sc2;
  logic [1:0]  sc3;

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_ADDR_WIDTH(5), .LOAD_LATENCY(1), .COUNT_WIDTH(16)) u_l1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .ex_branch_taken(ex_branch_taken),
    .ext_stall(ext_stall), .pc_write(o0[5]), .ifid_write(o0[4]), .ifid_flush(o0[3]),
    .idex_bubble(o0[2]), .idex_flush(o0[1]), .stall_active(o0[0]), .stall_cycles(sc0));

  hazard_control_unit #(.REG_ADDR_WIDTH(5), .LOAD_LATENCY(3), .COUNT_WIDTH(16)) u_l3 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .ex_branch_taken(ex_branch_taken),
    .ext_stall(ext_stall), .pc_write(o1[5]), .ifid_write(o1[4]), .ifid_flush(o1[3]),
    .idex_bubble(o1[2]), .idex_flush(o1[1]), .stall_active(o1[0]), .stall_cycles(sc1));

  hazard_control_unit #(.REG_ADDR_WIDTH(5), .LOAD_LATENCY(2), .COUNT_WIDTH(16)) u_l2 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .ex_branch_taken(ex_branch_taken),
    .ext_stall(ext_stall), .pc_write(o2[5]), .ifid_write(o2[4]), .ifid_flush(o2[3]),
    .idex_bubble(o2[2]), .idex_flush(o2[1]), .stall_active(o2[0]), .stall_cycles(sc2));

  hazard_control_unit #(.REG_ADDR_WIDTH(5), .LOAD_LATENCY(1), .COUNT_WIDTH(2)) u_sat (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .ex_branch_taken(ex_branch_taken),
    .ext_stall(ext_stall), .pc_write(o3[5]), .ifid_write(o3[4]), .ifid_flush(o3[3]),
    .idex_bubble(o3[2]), .idex_flush(o3[1]), .stall_active(o3[0]), .stall_cycles(sc3));

  // Output vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush, stall_active}
  localparam logic [5:0] ZERO = 6'b000000;
  localparam logic [5:0] DEF  = 6'b110000;
  localparam logic [5:0] STL  = 6'b000101;
  localparam logic [5:0] BRS  = 6'b111011;
  localparam logic [5:0] FRZ  = 6'b000001;

  typedef struct {
    int         dut;
    logic [5:0] outs;
    int         sc;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_out(input int dut, input logic [5:0] e, input int esc, input string name);
    exp_t x;
    x.dut = dut; x.outs = e; x.sc = esc; x.name = name;
    sb.push_back(x);
  endtask

  // One cycle: drive inputs just after the rising edge and queue the expected response.
  task automatic step(input logic rst, input logic mr, input logic [4:0] exrt, input logic [4:0] rs,
                      input logic [4:0] rt, input logic use_rt, input logic br, input logic ext,
                      input int dut, input logic [5:0] e, input int esc, input string name);
    @(posedge clk);
    #1;
    reset = rst; idex_mem_read = mr; idex_rt = exrt; id_rs = rs; id_rt = rt;
    id_uses_rt = use_rt; ex_branch_taken = br; ext_stall = ext;
    expect_out(dut, e, esc, name);
  endtask

  task automatic rst_step(input int dut);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, dut, ZERO, 0, "reset");
  endtask

  task automatic haz(input int dut, input logic br, input logic ext, input logic [5:0] e,
                     input int esc, input string name);
    step(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, br, ext, dut, e, esc, name);
  endtask

  task automatic idle(input int dut, input int esc, input string name);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, dut, DEF, esc, name);
  endtask

  // Monitor: on each falling edge, compare every queued expectation for this cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        exp_t x;
        logic [5:0] act;
        int asc;
        x = sb.pop_front();
        case (x.dut)
          0: begin act = o0; asc = int'(sc0); end
          1: begin act = o1; asc = int'(sc1); end
          2: begin act = o2; asc = int'(sc2); end
          default: begin act = o3; asc = int'(sc3); end
        endcase
        checks++;
        if (act !== x.outs || asc != x.sc) begin
          errors++;
          $display("FAIL %s (dut %0d): outs=%b stall_cycles=%0d, expected outs=%b stall_cycles=%0d",
                   x.name, x.dut, act, asc, x.outs, x.sc);
        end
      end
    end
  end

  initial begin
    // Reset state of all configurations.
    rst_step(0);
    expect_out(1, ZERO, 0, "reset_l3");
    expect_out(2, ZERO, 0, "reset_l2");
    expect_out(3, ZERO, 0, "reset_sat");

    // LOAD_LATENCY = 1 single-cycle stall.
    idle(0, 0, "l1_idle");
    haz(0, 1'b0, 1'b0, STL, 0, "l1_stall");
    idle(0, 1, "l1_after");

    // $zero exclusion and Rt use qualification.
    step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 0, DEF, 1, "zero_reg");
    step(1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 0, DEF, 1, "rt_unused");
    step(1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 0, STL, 1, "rt_used");
    idle(0, 2, "rt_after");

    // LOAD_LATENCY = 3 full stall.
    rst_step(1);
    haz(1, 1'b0, 1'b0, STL, 0, "l3_c1");
    haz(1, 1'b0, 1'b0, STL, 1, "l3_c2");
    haz(1, 1'b0, 1'b0, STL, 2, "l3_c3");
    idle(1, 3, "l3_c4");

    // Branch aborts a LOAD_LATENCY = 3 stall in its second cycle.
    rst_step(1);
    haz(1, 1'b0, 1'b0, STL, 0, "br_c1");
    haz(1, 1'b1, 1'b0, BRS, 1, "br_c2");
    idle(1, 1, "br_c3");
    idle(1, 1, "br_c4");

    // ext_stall freezes a LOAD_LATENCY = 2 stall.
    rst_step(2);
    haz(2, 1'b0, 1'b0, STL, 0, "frz_c1");
    haz(2, 1'b0, 1'b1, FRZ, 1, "frz_c2");
    haz(2, 1'b0, 1'b1, FRZ, 1, "frz_c3");
    haz(2, 1'b0, 1'b0, STL, 1, "frz_c4");
    idle(2, 2, "frz_c5");

    // Asynchronous reset in the middle of a stall.
    rst_step(1);
    haz(1, 1'b0, 1'b0, STL, 0, "ar_c1");
    step(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1, ZERO, 0, "async_rst");
    idle(1, 0, "post_rst");

    // Counter saturation with COUNT_WIDTH = 2.
    rst_step(3);
    haz(3, 1'b0, 1'b0, STL, 0, "sat_c1");
    haz(3, 1'b0, 1'b0, STL, 1, "sat_c2");
    haz(3, 1'b0, 1'b0, STL, 2, "sat_c3");
    haz(3, 1'b0, 1'b0, STL, 3, "sat_c4");
    haz(3, 1'b0, 1'b0, STL, 3, "sat_c5");
    idle(3, 3, "sat_hold1");
    idle(3, 3, "sat_hold2");

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
